// File: rtl/joy_db15_responder.sv
// Device end of the DB15 joystick serial link: snapshots both players' buttons on the
// host load strobe, then shifts the frame out LSB-first on each host clock rising edge.
//
// state   | meaning
// S_IDLE  | after reset, waiting for the first load strobe
// S_LOAD  | load held low, shift register tracks the button word
// S_SHIFT | frame in progress, one bit per host clock rising edge
// S_DONE  | frame complete, TAIL being shifted out
module joy_db15_responder #(
   parameter int   BITS_PP = 12,
   parameter bit   ACT_LOW = 1'b1,
   parameter logic TAIL    = 1'b1,
   parameter int   TIMEOUT = 1000000
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [BITS_PP-1:0] p1_buttons,
   input  logic [BITS_PP-1:0] p2_buttons,
   input  logic               joy_clk,
   input  logic               joy_load,
   output logic               joy_data,
   output logic               frame_done,
   output logic [5:0]         bit_index,
   output logic               link_active
);

   localparam int            N      = 2 * BITS_PP;
   localparam logic [5:0]    LAST   = 6'(N);
   localparam int            TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   state_t         state, state_nxt;
   logic [N-1:0]   shreg, shreg_nxt, frame_word;
   logic [5:0]     bit_index_nxt;
   logic           frame_done_nxt;
   logic           clk_meta, clk_sync, clk_prev;
   logic           ld_meta, ld_sync, ld_prev;
   logic           clk_rise, load_fall;
   logic [TW-1:0]  to_cnt;

   // Two-flop synchronisers plus an edge-detect flop; idle level of both pins is high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_meta <= 1'b1;
         clk_sync <= 1'b1;
         clk_prev <= 1'b1;
         ld_meta  <= 1'b1;
         ld_sync  <= 1'b1;
         ld_prev  <= 1'b1;
      end else begin
         clk_meta <= joy_clk;
         clk_sync <= clk_meta;
         clk_prev <= clk_sync;
         ld_meta  <= joy_load;
         ld_sync  <= ld_meta;
         ld_prev  <= ld_sync;
      end
   end

   assign clk_rise   = clk_sync & ~clk_prev;
   assign load_fall  = ~ld_sync & ld_prev;
   assign frame_word = {p2_buttons, p1_buttons} ^ {N{ACT_LOW}};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         shreg      <= {N{TAIL}};
         joy_data   <= TAIL;
         bit_index  <= 6'd0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         shreg      <= shreg_nxt;
         joy_data   <= shreg[0];
         bit_index  <= bit_index_nxt;
         frame_done <= frame_done_nxt;
      end
   end

   // Load low overrides everything, so a coincident clock edge never shifts.
   always_comb begin
      state_nxt      = state;
      shreg_nxt      = shreg;
      bit_index_nxt  = bit_index;
      frame_done_nxt = 1'b0;
      if (!ld_sync) begin
         state_nxt     = S_LOAD;
         shreg_nxt     = frame_word;
         bit_index_nxt = 6'd0;
      end else begin
         case (state)
            S_LOAD: state_nxt = S_SHIFT;
            S_SHIFT: begin
               if (clk_rise) begin
                  shreg_nxt     = {TAIL, shreg[N-1:1]};
                  bit_index_nxt = bit_index + 6'd1;
                  if (bit_index + 6'd1 == LAST) begin
                     state_nxt      = S_DONE;
                     frame_done_nxt = 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (clk_rise) shreg_nxt = {TAIL, shreg[N-1:1]};
            end
            default: ;
         endcase
      end
   end

   // Link watchdog: restarted by every load fall, saturates at TIMEOUT (0 never expires).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt      <= '0;
         link_active <= 1'b0;
      end else if (load_fall) begin
         to_cnt      <= '0;
         link_active <= 1'b1;
      end else if (to_cnt != TO_MAX) begin
         to_cnt <= to_cnt + TW'(1);
         if (to_cnt + TW'(1) == TO_MAX) link_active <= 1'b0;
      end
   end

endmodule

// File: tb/tb_joy_db15_responder.sv
// Host-side bench for joy_db15_responder: drives load/clock pins like the adapter poller
// and scores every received bit against a queue of expected bits.
module tb_joy_db15_responder;

   localparam int HALF = 8;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic [11:0] p1_buttons = 12'h000;
   logic [11:0] p2_buttons = 12'h000;
   logic        joy_clk = 1'b1;
   logic        joy_load = 1'b1;
   logic        joy_data;
   logic        frame_done;
   logic [5:0]  bit_index;
   logic        link_active;

   int checks = 0;
   int errors = 0;
   int fd_cnt = 0;
   logic exp_q[$];

   joy_db15_responder #(
      .BITS_PP(12), .ACT_LOW(1'b1), .TAIL(1'b1), .TIMEOUT(100)
   ) dut (
      .clk(clk_sys), .reset_n(reset_n),
      .p1_buttons(p1_buttons), .p2_buttons(p2_buttons),
      .joy_clk(joy_clk), .joy_load(joy_load),
      .joy_data(joy_data), .frame_done(frame_done),
      .bit_index(bit_index), .link_active(link_active)
   );

   always #10 clk_sys = ~clk_sys;

   always @(negedge clk_sys) if (frame_done) fd_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   function automatic logic [23:0] frame_of(input logic [11:0] a, input logic [11:0] b);
      return ~{b, a};
   endfunction

   task automatic start_load(input logic [11:0] a, input logic [11:0] b);
      logic [23:0] f;
      p1_buttons = a;
      p2_buttons = b;
      f = frame_of(a, b);
      exp_q.delete();
      for (int i = 0; i < 24; i++) exp_q.push_back(f[i]);
      joy_load = 1'b0;
   endtask

   task automatic load_pulse(input logic [11:0] a, input logic [11:0] b);
      start_load(a, b);
      wait_clk(HALF);
      joy_load = 1'b1;
      wait_clk(HALF);
   endtask

   task automatic shift_bits(input int n, input string tag, output logic [31:0] word);
      logic e;
      word = '0;
      for (int i = 0; i < n; i++) begin
         joy_clk = 1'b0;
         wait_clk(HALF);
         if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check(tag, {31'd0, joy_data}, {31'd0, e});
         end
         word[i] = joy_data;
         joy_clk = 1'b1;
         wait_clk(HALF);
      end
   endtask

   initial begin
      logic [31:0] w;
      logic [11:0] ra, rb;
      int fd0;

      wait_clk(3);
      check("rst_joy_data", {31'd0, joy_data}, 32'd1);
      check("rst_bit_index", {26'd0, bit_index}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_link_active", {31'd0, link_active}, 32'd0);
      reset_n = 1'b1;
      wait_clk(4);

      // Basic frame, then overrun past the end
      fd0 = fd_cnt;
      load_pulse(12'h009, 12'h000);
      check("t1_link_active", {31'd0, link_active}, 32'd1);
      shift_bits(24, "t1_bit", w);
      check("t1_word", w, 32'h00FF_FFF6);
      check("t1_frame_done", 32'(fd_cnt - fd0), 32'd1);
      check("t1_bit_index", {26'd0, bit_index}, 32'd24);
      for (int i = 0; i < 4; i++) exp_q.push_back(1'b1);
      shift_bits(4, "t2_tail", w);
      check("t2_tail_word", w, 32'h0000_000F);
      check("t2_frame_done", 32'(fd_cnt - fd0), 32'd1);
      check("t2_bit_index", {26'd0, bit_index}, 32'd24);

      // Buttons change mid-frame
      load_pulse(12'h000, 12'h000);
      shift_bits(5, "t3_bit", w);
      p1_buttons = 12'hFFF;
      shift_bits(19, "t3_bit", w);
      check("t3_tail_word", w, 32'h0007_FFFF);

      // Abort after 10 bits, then a full frame
      fd0 = fd_cnt;
      load_pulse(12'h5A3, 12'h0C6);
      shift_bits(10, "t4_abort_bit", w);
      check("t4_abort_index", {26'd0, bit_index}, 32'd10);
      load_pulse(12'h3C1, 12'hA55);
      check("t4_restart_index", {26'd0, bit_index}, 32'd0);
      check("t4_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
      shift_bits(24, "t4_bit", w);
      check("t4_word", w, {8'd0, frame_of(12'h3C1, 12'hA55)});
      check("t4_frame_done", 32'(fd_cnt - fd0), 32'd1);

      // Load fall coincident with a clock rise
      load_pulse(12'h0F0, 12'h00F);
      shift_bits(6, "t5_pre_bit", w);
      joy_clk = 1'b0;
      wait_clk(HALF);
      start_load(12'h801, 12'h7FE);
      joy_clk = 1'b1;
      wait_clk(HALF);
      check("t5_sim_index", {26'd0, bit_index}, 32'd0);
      check("t5_sim_data", {31'd0, joy_data}, {31'd0, exp_q[0]});
      joy_load = 1'b1;
      wait_clk(HALF);
      shift_bits(24, "t5_bit", w);
      check("t5_word", w, {8'd0, frame_of(12'h801, 12'h7FE)});

      // Watchdog
      joy_load = 1'b0;
      wait_clk(HALF);
      check("t5_link_set", {31'd0, link_active}, 32'd1);
      joy_load = 1'b1;
      wait_clk(40);
      check("t5_link_hold", {31'd0, link_active}, 32'd1);
      wait_clk(70);
      check("t5_link_drop", {31'd0, link_active}, 32'd0);
      joy_load = 1'b0;
      wait_clk(HALF);
      check("t5_link_reset", {31'd0, link_active}, 32'd1);
      joy_load = 1'b1;
      wait_clk(HALF);

      // Random frames
      for (int f = 0; f < 12; f++) begin
         ra = 12'($urandom);
         rb = 12'($urandom);
         fd0 = fd_cnt;
         load_pulse(ra, rb);
         shift_bits(24, "t6_bit", w);
         check("t6_word", w, {8'd0, frame_of(ra, rb)});
         check("t6_frame_done", 32'(fd_cnt - fd0), 32'd1);
      end

      // Reset mid-frame
      load_pulse(12'hFFF, 12'hFFF);
      shift_bits(5, "t6r_pre_bit", w);
      reset_n = 1'b0;
      #1;
      check("t6r_joy_data", {31'd0, joy_data}, 32'd1);
      check("t6r_bit_index", {26'd0, bit_index}, 32'd0);
      check("t6r_link_active", {31'd0, link_active}, 32'd0);
      wait_clk(3);
      reset_n = 1'b1;
      wait_clk(HALF);
      exp_q.delete();
      for (int i = 0; i < 3; i++) exp_q.push_back(1'b1);
      shift_bits(3, "t6r_idle_bit", w);
      fd0 = fd_cnt;
      load_pulse(12'h123, 12'hABC);
      shift_bits(24, "t6r_bit", w);
      check("t6r_word", w, {8'd0, frame_of(12'h123, 12'hABC)});
      check("t6r_frame_done", 32'(fd_cnt - fd0), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
